// File: rtl/instruction_rom_loader_if.sv
// Purpose: byte-stream load handshake between the board-level loader
//          (switches/UART front end) and instruction_rom_loader.
// Signals:
//   load_start - one-cycle pulse, begin a new load at address 0
//   load_valid - load_data holds a valid byte
//   load_data  - program byte
//   load_last  - marks the final byte, sampled with load_valid
//   load_ready - loader accepts a byte this cycle
// Modports: master = loader front end, slave = instruction_rom_loader.
interface instruction_rom_loader_if;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;

  modport master (
    output load_start, load_valid, load_data, load_last,
    input  load_ready
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    output load_ready
  );
endinterface

// File: rtl/instruction_rom_loader.sv
// Purpose: program memory for the 8-bit single-cycle core. A DEPTH x 8 RAM
//          is filled from a byte stream while the core is held in reset, then
//          the core is released and fetches with zero-latency reads.
// Ports:
//   CLK          - system clock, rising edge
//   reset        - asynchronous, active-low reset
//   lif          - load handshake (slave side of instruction_rom_loader_if)
//   read_address - fetch address from the core's PC
//   instruction  - fetched byte, combinational from read_address
//   cpu_reset_n  - active-low reset to the core, high only in RUN
//   prog_len     - number of bytes loaded (0..DEPTH)
//   running      - high in RUN
//   load_checksum- (LOAD_CHECKSUM_EN only) mod-256 sum of accepted bytes
// Optional feature macro: LOAD_CHECKSUM_EN
module instruction_rom_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  FILL   = 8'h00
) (
  input  logic                CLK,
  input  logic                reset,
  instruction_rom_loader_if.slave lif,
  input  logic [ADDR_W-1:0]   read_address,
  output logic [7:0]          instruction,
  output logic                cpu_reset_n,
  output logic [ADDR_W:0]     prog_len,
  output logic                running
`ifdef LOAD_CHECKSUM_EN
  ,output logic [7:0]         load_checksum
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_prog_len;
  logic                r_load_ready;
  logic                r_cpu_reset_n;
  logic                r_running;
  logic [7:0]          r_mem [DEPTH];
`ifdef LOAD_CHECKSUM_EN
  logic [7:0]          r_checksum;
`endif

  logic                w_accept;
  logic                w_in_range;

  // A start pulse overrides any byte offered in the same cycle.
  assign w_accept = (r_state == LOAD) && r_load_ready && lif.load_valid
                    && !lif.load_start;

  // RAM has no reset; a zero prog_len masks stale contents.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_mem[r_ptr] <= lif.load_data;
    end
  end

  // Control FSM; all outputs are registered alongside the state.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_prog_len    <= '0;
      r_load_ready  <= 1'b0;
      r_cpu_reset_n <= 1'b0;
      r_running     <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      r_checksum    <= 8'h00;
`endif
    end else if (lif.load_start) begin
      r_state       <= LOAD;
      r_ptr         <= '0;
      r_prog_len    <= '0;
      r_load_ready  <= 1'b1;
      r_cpu_reset_n <= 1'b0;
      r_running     <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      r_checksum    <= 8'h00;
`endif
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            r_prog_len <= r_prog_len + (ADDR_W+1)'(1);
`ifdef LOAD_CHECKSUM_EN
            r_checksum <= r_checksum + lif.load_data;
`endif
            // The pointer holds at the top address so a full load never wraps.
            if (r_ptr != LAST_ADDR) begin
              r_ptr <= r_ptr + ADDR_W'(1);
            end
            if (lif.load_last || (r_ptr == LAST_ADDR)) begin
              r_state       <= RUN;
              r_load_ready  <= 1'b0;
              r_cpu_reset_n <= 1'b1;
              r_running     <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Zero-latency fetch; unsigned compare, prog_len is one bit wider.
  assign w_in_range  = ({1'b0, read_address} < r_prog_len);
  assign instruction = (r_running && w_in_range) ? r_mem[read_address] : FILL;

  assign lif.load_ready = r_load_ready;
  assign cpu_reset_n    = r_cpu_reset_n;
  assign prog_len       = r_prog_len;
  assign running        = r_running;
`ifdef LOAD_CHECKSUM_EN
  assign load_checksum  = r_checksum;
`endif

endmodule

// File: tb/tb_instruction_rom_loader.sv
// Purpose: directed self-checking bench for instruction_rom_loader.
// Exercises reset, back-to-back and gapped loads, a full 256-byte fill,
// abort by load_start, and reset mid-load (plus checksum when
// LOAD_CHECKSUM_EN is defined).
module tb_instruction_rom_loader;
  logic       CLK;
  logic       reset;
  logic [7:0] read_address;
  logic [7:0] instruction;
  logic       cpu_reset_n;
  logic [8:0] prog_len;
  logic       running;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0] load_checksum;
`endif

  int checks = 0;
  int errors = 0;

  instruction_rom_loader_if lif ();

  instruction_rom_loader #(.ADDR_W(8), .FILL(8'h00)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .lif          (lif),
    .read_address (read_address),
    .instruction  (instruction),
    .cpu_reset_n  (cpu_reset_n),
    .prog_len     (prog_len),
    .running      (running)
`ifdef LOAD_CHECKSUM_EN
    ,.load_checksum (load_checksum)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock, then settle just after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulseStart();
    lif.load_start = 1'b1;
    tick(1);
    lif.load_start = 1'b0;
  endtask

  // Offer one byte and hold it for one accepting edge.
  task automatic applyStimulus(input logic [7:0] data, input logic last);
    int n = 0;
    while (!lif.load_ready && n < 20) begin
      tick(1);
      n++;
    end
    if (!lif.load_ready) checkOutput("readyTimeout", 32'(lif.load_ready), 32'd1);
    lif.load_valid = 1'b1;
    lif.load_data  = data;
    lif.load_last  = last;
    tick(1);
    lif.load_valid = 1'b0;
    lif.load_last  = 1'b0;
  endtask

  task automatic checkFetch(input string tag, input logic [7:0] addr,
                            input logic [7:0] expected);
    read_address = addr;
    #1;
    checkOutput(tag, 32'(instruction), 32'(expected));
  endtask

  initial begin
    reset          = 1'b0;
    lif.load_start = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data  = 8'h00;
    lif.load_last  = 1'b0;
    read_address   = 8'h00;

    // Reset then idle
    tick(3);
    reset = 1'b1;
    tick(1);
    checkOutput("rstCpuReset", 32'(cpu_reset_n), 32'd0);
    checkOutput("rstReady", 32'(lif.load_ready), 32'd0);
    checkOutput("rstProgLen", 32'(prog_len), 32'd0);
    checkOutput("rstRunning", 32'(running), 32'd0);
    checkFetch("rstFetch00", 8'h00, 8'h00);
    checkFetch("rstFetchFF", 8'hFF, 8'h00);

    // Back-to-back load of three bytes
    pulseStart();
    checkOutput("loadReady", 32'(lif.load_ready), 32'd1);
    checkOutput("loadCpuReset", 32'(cpu_reset_n), 32'd0);
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h86, 1'b0);
    checkOutput("midRunning", 32'(running), 32'd0);
    checkFetch("midFetchMasked", 8'h00, 8'h00);
    applyStimulus(8'hC3, 1'b1);
    checkOutput("b2bRunning", 32'(running), 32'd1);
    checkOutput("b2bCpuReset", 32'(cpu_reset_n), 32'd1);
    checkOutput("b2bReady", 32'(lif.load_ready), 32'd0);
    checkOutput("b2bProgLen", 32'(prog_len), 32'd3);
    checkFetch("b2bFetch0", 8'h00, 8'h41);
    checkFetch("b2bFetch1", 8'h01, 8'h86);
    checkFetch("b2bFetch2", 8'h02, 8'hC3);
    checkFetch("b2bFetch3", 8'h03, 8'h00);

    // Gapped handshake with junk data and a stray load_last while idle
    pulseStart();
    applyStimulus(8'h41, 1'b0);
    lif.load_data = 8'hEE;
    lif.load_last = 1'b1;
    tick(2);
    lif.load_last = 1'b0;
    checkOutput("gapProgLen1", 32'(prog_len), 32'd1);
    checkOutput("gapStillLoad", 32'(lif.load_ready), 32'd1);
    applyStimulus(8'h86, 1'b0);
    lif.load_data = 8'hEE;
    tick(2);
    checkOutput("gapProgLen2", 32'(prog_len), 32'd2);
    applyStimulus(8'hC3, 1'b1);
    checkOutput("gapRunning", 32'(running), 32'd1);
    checkOutput("gapProgLen", 32'(prog_len), 32'd3);
    checkFetch("gapFetch0", 8'h00, 8'h41);
    checkFetch("gapFetch1", 8'h01, 8'h86);
    checkFetch("gapFetch2", 8'h02, 8'hC3);

    // Full 256-byte fill without load_last
    pulseStart();
    for (int i = 0; i < 255; i++) applyStimulus(8'(i), 1'b0);
    checkOutput("fullPre255", 32'(prog_len), 32'd255);
    checkOutput("fullPreRunning", 32'(running), 32'd0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("fullRunning", 32'(running), 32'd1);
    checkOutput("fullProgLen", 32'(prog_len), 32'd256);
    checkOutput("fullReady", 32'(lif.load_ready), 32'd0);
    checkFetch("fullFetchFF", 8'hFF, 8'hFF);
    checkFetch("fullFetch80", 8'h80, 8'h80);
    checkFetch("fullFetch00", 8'h00, 8'h00);

    // Abort from RUN with a simultaneous byte offer
    lif.load_start = 1'b1;
    lif.load_valid = 1'b1;
    lif.load_data  = 8'h99;
    tick(1);
    lif.load_start = 1'b0;
    lif.load_valid = 1'b0;
    checkOutput("abortRunning", 32'(running), 32'd0);
    checkOutput("abortCpuReset", 32'(cpu_reset_n), 32'd0);
    checkOutput("abortProgLen", 32'(prog_len), 32'd0);
    checkOutput("abortReady", 32'(lif.load_ready), 32'd1);
`ifdef LOAD_CHECKSUM_EN
    checkOutput("abortChecksum", 32'(load_checksum), 32'd0);
`endif
    checkFetch("abortFetchMasked", 8'hFF, 8'h00);
    applyStimulus(8'h12, 1'b1);
    checkOutput("reloadProgLen", 32'(prog_len), 32'd1);
    checkFetch("reloadFetch0", 8'h00, 8'h12);
    checkFetch("reloadFetch1", 8'h01, 8'h00);

    // Checksum, then asynchronous reset mid-load
    pulseStart();
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h20, 1'b0);
    checkOutput("csProgLen", 32'(prog_len), 32'd2);
`ifdef LOAD_CHECKSUM_EN
    checkOutput("csSum", 32'(load_checksum), 32'h10);
`endif
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midRstProgLen", 32'(prog_len), 32'd0);
    checkOutput("midRstReady", 32'(lif.load_ready), 32'd0);
    checkOutput("midRstRunning", 32'(running), 32'd0);
    checkOutput("midRstCpuReset", 32'(cpu_reset_n), 32'd0);
`ifdef LOAD_CHECKSUM_EN
    checkOutput("midRstChecksum", 32'(load_checksum), 32'd0);
`endif
    checkFetch("midRstFetch", 8'h00, 8'h00);
    tick(1);
    reset = 1'b1;
    tick(2);
    checkOutput("idleAfterRst", 32'(lif.load_ready), 32'd0);
    checkOutput("idleProgLen", 32'(prog_len), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_rom_loader.md
Name: instruction_rom_loader

Overview:
- Program-side counterpart of the 8-bit single-cycle core: answers the core's fetch address with an instruction byte the same cycle.
- Contains a DEPTH x 8 instruction RAM, loaded from a byte stream over a valid/ready handshake.
- Holds the core in reset while a program is loaded, then releases it so the core's PC restarts at 0.
- Sits between the board-level loader (switches/UART front end) and the core's instruction/read_address pins.

Parameters:
- ADDR_W, 8, fetch/load address width; DEPTH = 2**ADDR_W.
- FILL, 8'h00, instruction returned when not running or when the address is outside the loaded program.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; reset=0 clears all state.
- load_start  input  1  one-cycle pulse: begin a new load at address 0.
- load_valid  input  1  load_data holds a valid byte.
- load_data  input  8  program byte.
- load_last  input  1  qualifies the final byte; sampled with load_valid.
- load_ready  output  1  loader accepts a byte this cycle.
- read_address  input  ADDR_W  fetch address from the core's PC.
- instruction  output  8  fetched instruction, combinational from read_address.
- cpu_reset_n  output  1  active-low reset to the core; high only in RUN.
- prog_len  output  ADDR_W+1  number of bytes loaded (0..DEPTH).
- running  output  1  state==RUN.

Behaviour:
- States: IDLE, LOAD, RUN.
- Reset (reset=0, asynchronous):
  - state=IDLE, write pointer=0, prog_len=0.
  - load_ready=0, cpu_reset_n=0, running=0, instruction=FILL.
  - RAM contents are not cleared; prog_len=0 masks them.
- IDLE:
  - load_start=1 moves to LOAD next edge; pointer=0, prog_len=0.
- LOAD:
  - load_ready=1 (registered by the state).
  - A byte is accepted on a rising edge with load_valid=1 and load_ready=1: RAM[ptr]<=load_data, ptr<=ptr+1, prog_len<=prog_len+1.
  - Accepted byte with load_last=1 moves to RUN next edge.
  - Accepted byte at ptr=DEPTH-1 moves to RUN regardless of load_last; prog_len=DEPTH and ptr does not wrap.
  - load_valid=0 keeps the state and writes nothing.
  - load_last without load_valid is ignored.
- RUN:
  - cpu_reset_n=1 and running=1, both registered; high from the first edge after the final accepted byte.
  - load_ready=0.
- Fetch:
  - instruction = RAM[read_address] when running=1 and read_address < prog_len; otherwise FILL.
  - Asynchronous read, zero latency, as the single-cycle core requires.
- load_start in LOAD or RUN:
  - Aborts and re-enters LOAD next edge; pointer=0, prog_len=0, cpu_reset_n=0 on that edge.
  - load_start has priority over a simultaneous byte accept, which is dropped.
- Zero-length program is impossible; at least one byte is accepted before RUN.
- Reset mid-load returns to IDLE with prog_len=0; the partial program is never executed.
- Width rule: prog_len is ADDR_W+1 bits so the value DEPTH is representable.
- The comparison read_address < prog_len is unsigned.

Optional Feature:
- Macro LOAD_CHECKSUM_EN.
- Defined:
  - Adds output load_checksum [7:0]: modulo-256 sum of all accepted bytes of the current load.
  - Cleared to 0 by reset and by load_start.
  - Updated on each accept; holds its value in RUN.
- Undefined:
  - Port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release -> cpu_reset_n=0, load_ready=0, prog_len=0, instruction=8'h00 for any read_address.
- Load 3 bytes 8'h41, 8'h86, 8'hC3 with load_last on the 3rd, back-to-back valid -> prog_len=3; running=1 and cpu_reset_n=1 one edge after the 3rd accept; read_address=1 gives 8'h86; read_address=3 gives FILL.
- Gapped handshake: load_valid low for 2 cycles between bytes -> no extra writes, prog_len counts only accepted bytes, same RAM contents as the back-to-back case.
- Full fill: 256 bytes, value=index, no load_last -> RUN after the 256th accept; prog_len=9'd256; read_address=8'hFF gives 8'hFF.
- Abort: in RUN pulse load_start together with load_valid -> next edge state LOAD, cpu_reset_n=0, prog_len=0, that byte not written; reload 1 byte 8'h12 -> read_address=0 gives 8'h12.
- Checksum (LOAD_CHECKSUM_EN): bytes 8'hF0, 8'h20 -> load_checksum=8'h10; reset mid-load -> state IDLE, prog_len=0, load_checksum=0.
